jk_state_monitor: RTL
=====================

JK_STATE_MONITOR -- requirements
Module: jk_state_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, width of dwell and transition counters.
REQ-003 SHALL have parameter TIMEOUT, default 16, dwell length raising a timeout event (1 <= TIMEOUT < 2^CNT_W).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have ports F1, F2  input  1 each  state bits from the upstream JK-flip-flop circuit; state code S = {F1,F2}.
REQ-007 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-009 SHALL have port evt_code  output  2  head event type: 01 step, 10 jump, 11 timeout.
REQ-010 SHALL have port evt_state  output  2  state code carried by head event.
REQ-011 SHALL have port evt_dwell  output  CNT_W  dwell carried by head event.
REQ-012 SHALL have port trans_cnt  output  CNT_W  total transitions since reset.
REQ-013 SHALL have port overflow  output  1  sticky: an event was dropped.

Function
REQ-014 SHALL register previous state s_q and compare S with s_q every cycle; S != s_q is a transition.
REQ-015 SHALL classify transition: exactly one bit changed -> code 01; both bits changed -> code 10.
REQ-016 SHALL keep dwell_q: on a transition edge, record dwell_q and set dwell_q to 0; otherwise dwell_q <= dwell_q+1, saturating at 2^CNT_W-1.
REQ-017 SHALL push record {code, new S, recorded dwell_q} into the FIFO on the same edge that samples the transition; evt_valid rises after that edge if the FIFO was empty (latency 1 edge).
REQ-018 SHALL increment trans_cnt by 1 per transition, wrapping modulo 2^CNT_W.
REQ-019 SHALL present FIFO head on evt_code/evt_state/evt_dwell while evt_valid=1; pop on edge where evt_valid && evt_ready; outputs stable while valid && !ready.
REQ-020 SHALL, on push while full without pop, drop the new record, keep FIFO contents, and set overflow to 1 until reset.
REQ-021 SHALL, on simultaneous push and pop while full, accept both with no overflow; when empty, push only (no bypass to the same cycle's outputs).
REQ-022 SHALL hold evt_valid=0 and ignore evt_ready while FIFO is empty.

Reset
REQ-023 SHALL, on reset=0, immediately and without clock set s_q=00, dwell_q=0, trans_cnt=0, overflow=0, FIFO empty, evt_valid=0, evt_code/evt_state/evt_dwell=0.
REQ-024 SHALL discard all queued events on reset asserted mid-operation; first edge after release compares S against 00.

Configuration
REQ-025 SHALL compile the timeout feature only when macro JK_MON_TIMEOUT_EN is defined.
REQ-026 SHALL, with JK_MON_TIMEOUT_EN, push {11, s_q, TIMEOUT} on the edge where no transition occurs and dwell_q+1 == TIMEOUT (once per dwell period), subject to REQ-020/021.
REQ-027 SHALL, without JK_MON_TIMEOUT_EN, never produce code 11; TIMEOUT is unused.

Structure
REQ-028 SHALL place event-code constants (EVT_STEP=01, EVT_JUMP=10, EVT_TIMEOUT=11) and the event-record typedef in shared package jk_mon_pkg.
REQ-029 SHALL implement the queue as sub-module jk_evt_fifo (parameterised DEPTH, record width, full/empty, synchronous push/pop, async active-low reset).

Verification
REQ-030 SHALL cover: hold S=00 for 5 edges then S=01, evt_ready=1 -> one event {01, 01, 5}, trans_cnt=1.
REQ-031 SHALL cover: S 00 -> 11 in one cycle -> event {10, 11, dwell}, trans_cnt increments by 1.
REQ-032 SHALL cover: evt_ready=0, 5 transitions, DEPTH=4 -> first 4 queued in order, overflow=1; then ready=1 drains exactly 4.
REQ-033 SHALL cover: FIFO full, transition with evt_ready=1 same edge -> count stays 4, overflow stays 0, newest record at tail.
REQ-034 SHALL cover: S held 20 edges, TIMEOUT=16 -> with JK_MON_TIMEOUT_EN exactly one {11, S, 16}; without it no event.
REQ-035 SHALL cover: reset=0 driven between clock edges with 3 events queued -> evt_valid, trans_cnt, overflow 0 before next edge; post-release S=00 gives no event.

Source files
------------

// File: rtl/jk_mon_pkg.sv
// Shared definitions for the JK state monitor.
//   EVT_STEP / EVT_JUMP / EVT_TIMEOUT : event type codes carried on evt_code
//   evt_hdr_t                         : fixed part of an event record {code, state};
//                                       the CNT_W-wide dwell field is appended by the user
//   classify_transition()             : step vs jump for two differing state codes
package jk_mon_pkg;

  localparam logic [1:0] EVT_STEP    = 2'b01;
  localparam logic [1:0] EVT_JUMP    = 2'b10;
  localparam logic [1:0] EVT_TIMEOUT = 2'b11;

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] state;
  } evt_hdr_t;

  localparam int unsigned EVT_HDR_W = $bits(evt_hdr_t);

  // Only meaningful when prev != cur: odd number of flipped bits means one bit moved.
  function automatic logic [1:0] classify_transition(input logic [1:0] prev,
                                                     input logic [1:0] cur);
    return (^(prev ^ cur)) ? EVT_STEP : EVT_JUMP;
  endfunction

endpackage

// File: rtl/jk_evt_fifo.sv
// Event queue for the JK state monitor.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset, empties the queue
//   i_push   : write i_data at the tail (ignored when full unless popping the same edge)
//   i_pop    : remove the head (ignored when empty)
//   o_data   : head record, forced to zero while empty
//   o_full   : DEPTH records held
//   o_empty  : no record held
module jk_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop on the same edge frees the slot, so a full queue still accepts the push.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/jk_state_monitor.sv
// Watches the 2-bit state {F1,F2} of an upstream JK flip-flop circuit and queues an event
// for every transition (step = one bit changed, jump = both changed) with the dwell time
// spent in the previous state.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   F1, F2     : observed state bits, S = {F1,F2}
//   evt_valid  : queue head holds an event
//   evt_ready  : consumer takes the head on this edge
//   evt_code   : head event type (01 step, 10 jump, 11 timeout)
//   evt_state  : state code carried by the head event
//   evt_dwell  : dwell count carried by the head event
//   trans_cnt  : transitions since reset, wrapping
//   overflow   : sticky, an event was dropped because the queue was full
// Build option: define JK_MON_TIMEOUT_EN to also queue a timeout event once per dwell
// period when a state has been held for TIMEOUT edges.
module jk_state_monitor
  import jk_mon_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             F1,
  input  logic             F2,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [1:0]       evt_state,
  output logic [CNT_W-1:0] evt_dwell,
  output logic [CNT_W-1:0] trans_cnt,
  output logic             overflow
);

  localparam int unsigned REC_W = EVT_HDR_W + CNT_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("jk_state_monitor: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || longint'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("jk_state_monitor: TIMEOUT must lie in [1, 2^CNT_W)");
  end

  logic [1:0]       r_s;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_trans_cnt;
  logic             r_overflow;

  logic [1:0]       w_s;
  logic             w_trans;
  logic             w_timeout;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  evt_hdr_t         w_hdr;
  logic [CNT_W-1:0] w_rec_dwell;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_head;

  assign w_s     = {F1, F2};
  assign w_trans = (w_s != r_s);

`ifdef JK_MON_TIMEOUT_EN
  logic [CNT_W:0] w_dwell_inc;

  // One bit wider so a saturated dwell never aliases onto TIMEOUT.
  assign w_dwell_inc = {1'b0, r_dwell} + {{CNT_W{1'b0}}, 1'b1};
  assign w_timeout   = ~w_trans && (w_dwell_inc == (CNT_W + 1)'(TIMEOUT));
`else
  assign w_timeout   = 1'b0;
`endif

  always_comb begin
    w_hdr.code  = classify_transition(r_s, w_s);
    w_hdr.state = w_s;
    w_rec_dwell = r_dwell;
`ifdef JK_MON_TIMEOUT_EN
    if (w_timeout) begin
      w_hdr.code  = EVT_TIMEOUT;
      w_hdr.state = r_s;
      w_rec_dwell = CNT_W'(TIMEOUT);
    end
`endif
  end

  assign w_rec  = {w_hdr, w_rec_dwell};
  assign w_push = w_trans | w_timeout;
  assign w_pop  = evt_valid & evt_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s         <= 2'b00;
      r_dwell     <= '0;
      r_trans_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_s <= w_s;
      if (w_trans) begin
        r_dwell     <= '0;
        r_trans_cnt <= r_trans_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!(&r_dwell)) begin
        r_dwell <= r_dwell + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  jk_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid                         = ~w_empty;
  assign {evt_code, evt_state, evt_dwell}  = w_head;
  assign trans_cnt                         = r_trans_cnt;
  assign overflow                          = r_overflow;

endmodule
